// File: rtl/insn_decode_pkg.sv
// -----------------------------------------------------------------------------
// insn_decode_pkg
// Shared definitions for the instruction decode stage:
//   - opcode constants for the special opcodes (prefix, branch, load-upper)
//   - immediate-width select encoding driven to the immediate generator
//   - immediate-shift select encoding driven to the immediate generator
//   - decode FSM state type
//   - helper that classifies an extension word as malformed
// Optional feature macro used by the importing files: INSN_DECODE_ILLEGAL_EN
// -----------------------------------------------------------------------------
package insn_decode_pkg;

  // Opcodes with special meaning to the decoder
  localparam logic [3:0] OP_PREFIX = 4'hF;
  localparam logic [3:0] OP_BRANCH = 4'hD;
  localparam logic [3:0] OP_LUI    = 4'hE;
  localparam logic [3:0] OP_IMM8   = 4'hC;

  // Immediate width select seen by the immediate generator
  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM4     = 2'd1,
    IMM8     = 2'd2,
    IMM12    = 2'd3
  } imm_width_e;

  // Immediate shift select seen by the immediate generator
  typedef enum logic [1:0] {
    SH_NONE = 2'd0,
    SH_1    = 2'd1,
    SH_8    = 2'd2
  } imm_shift_e;

  // Decode FSM: IDLE waits for a fresh instruction, EXT holds a prefix
  // word while waiting for its extension word.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXT  = 1'b1
  } dec_state_e;

  // An extension word must carry a zero top nibble. A nested prefix word
  // (top nibble 0xF) is therefore also caught by this test.
  function automatic logic ext_word_illegal(input logic [15:0] w);
    return (w[15:12] != 4'h0);
  endfunction

endpackage

// File: rtl/insn_decode_stage_field.sv
// -----------------------------------------------------------------------------
// insn_field_decode
// Purely combinational single-word field mapping, shared by the IDLE path
// (ordinary one-word instructions) and the EXT path (prefix + extension).
//
// Ports:
//   i_word      in  16  word currently presented by fetch
//   i_prefix    in  12  low 12 bits of the held prefix word
//   i_ext       in   1  1 = i_word is the extension of the held prefix
//   o_opcode    out  4  operation code
//   o_rd        out  4  destination register
//   o_rs        out  4  source register
//   o_imm_din   out 16  raw immediate source word
//   o_num_bits  out  2  immediate width select
//   o_shift     out  2  immediate shift select
//   o_illegal   out  1  malformed extension word
//
// Optional feature macro: INSN_DECODE_ILLEGAL_EN (extension word checking)
// -----------------------------------------------------------------------------
module insn_field_decode
  import insn_decode_pkg::*;
(
  input  logic [15:0] i_word,
  input  logic [11:0] i_prefix,
  input  logic        i_ext,
  output logic [3:0]  o_opcode,
  output logic [3:0]  o_rd,
  output logic [3:0]  o_rs,
  output logic [15:0] o_imm_din,
  output logic [1:0]  o_num_bits,
  output logic [1:0]  o_shift,
  output logic        o_illegal
);

  logic       w_ext_bad;
  logic [3:0] w_op;

  assign w_op = i_word[15:12];

`ifdef INSN_DECODE_ILLEGAL_EN
  assign w_ext_bad = ext_word_illegal(i_word);
`else
  // Extension words are taken unchecked in the default build
  assign w_ext_bad = 1'b0;
`endif

  // Map the presented word (or prefix + extension) onto decode fields
  always_comb begin
    o_opcode   = w_op;
    o_rd       = i_word[11:8];
    o_rs       = i_word[7:4];
    o_imm_din  = i_word;
    o_num_bits = IMM_NONE;
    o_shift    = SH_NONE;
    o_illegal  = 1'b0;

    if (i_ext) begin
      // Register fields come from the prefix in reversed nibble order;
      // the whole extension word is the 12-bit immediate source.
      o_opcode  = i_prefix[3:0];
      o_rd      = i_prefix[7:4];
      o_rs      = i_prefix[11:8];
      o_imm_din = i_word;
      o_illegal = w_ext_bad;
      if (w_ext_bad) begin
        o_num_bits = IMM_NONE;
      end else begin
        o_num_bits = IMM12;
      end
    end else begin
      case (w_op)
        4'h0, 4'h1, 4'h2, 4'h3,
        4'h4, 4'h5, 4'h6, 4'h7: begin
          o_num_bits = IMM_NONE;
          o_shift    = SH_NONE;
        end
        4'h8, 4'h9, 4'hA, 4'hB: begin
          o_num_bits = IMM4;
          o_shift    = SH_NONE;
        end
        OP_IMM8: begin
          o_num_bits = IMM8;
          o_shift    = SH_NONE;
        end
        OP_BRANCH: begin
          // Branch offsets are halfword aligned
          o_num_bits = IMM8;
          o_shift    = SH_1;
        end
        OP_LUI: begin
          o_num_bits = IMM8;
          o_shift    = SH_8;
        end
        default: begin
          // OP_PREFIX: never loaded into the output register on its own
          o_num_bits = IMM_NONE;
          o_shift    = SH_NONE;
        end
      endcase
    end
  end

endmodule

// File: rtl/insn_decode_stage.sv
// -----------------------------------------------------------------------------
// insn_decode_stage
// Registered decode stage between instruction fetch and the immediate
// generator / execute stage. Single-word instructions are decoded with a
// latency of one cycle; a prefix word (opcode 0xF) is held in the FSM and
// combined with the following extension word into one output.
//
// Ports:
//   clk             in   1     clock, rising edge
//   rst             in   1     asynchronous active-high reset
//   i_flush         in   1     synchronous discard of prefix and output reg
//   i_in_valid      in   1     fetch word valid
//   o_in_ready      out  1     stage can accept a word this cycle
//   i_in_instr      in   16    instruction word
//   i_in_pc         in   PC_W  address of i_in_instr
//   o_out_valid     out  1     decoded instruction valid
//   i_out_ready     in   1     downstream accepts
//   o_out_opcode    out  4     operation code
//   o_out_rd        out  4     destination register
//   o_out_rs        out  4     source register
//   o_imm_din       out  16    raw immediate source word
//   o_imm_num_bits  out  2     immediate width select
//   o_imm_shift     out  2     immediate shift select
//   o_out_pc        out  PC_W  PC of the first word of the instruction
//   o_out_illegal   out  1     malformed instruction flag
//
// Optional feature macro: INSN_DECODE_ILLEGAL_EN (flags malformed extension
// words; when undefined o_out_illegal is tied low).
// -----------------------------------------------------------------------------
module insn_decode_stage
  import insn_decode_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_flush,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [15:0]     i_in_instr,
  input  logic [PC_W-1:0] i_in_pc,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [3:0]      o_out_opcode,
  output logic [3:0]      o_out_rd,
  output logic [3:0]      o_out_rs,
  output logic [15:0]     o_imm_din,
  output logic [1:0]      o_imm_num_bits,
  output logic [1:0]      o_imm_shift,
  output logic [PC_W-1:0] o_out_pc,
  output logic            o_out_illegal
);

  dec_state_e      r_state;
  logic [11:0]     r_prefix;
  logic [PC_W-1:0] r_prefix_pc;

  logic            r_out_valid;
  logic [3:0]      r_out_opcode;
  logic [3:0]      r_out_rd;
  logic [3:0]      r_out_rs;
  logic [15:0]     r_imm_din;
  logic [1:0]      r_imm_num_bits;
  logic [1:0]      r_imm_shift;
  logic [PC_W-1:0] r_out_pc;
  logic            r_out_illegal;

  logic            w_in_ready;
  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_ext;
  logic            w_is_prefix;
  logic            w_load;

  logic [3:0]      w_dec_opcode;
  logic [3:0]      w_dec_rd;
  logic [3:0]      w_dec_rs;
  logic [15:0]     w_dec_imm;
  logic [1:0]      w_dec_num_bits;
  logic [1:0]      w_dec_shift;
  logic            w_dec_illegal;

  // Accept whenever the output register is empty or draining this cycle;
  // deliberately independent of i_in_valid.
  assign w_in_ready  = !r_out_valid || i_out_ready;
  assign w_in_fire   = i_in_valid && w_in_ready;
  assign w_out_fire  = r_out_valid && i_out_ready;
  assign w_ext       = (r_state == ST_EXT);
  assign w_is_prefix = (i_in_instr[15:12] == OP_PREFIX);

  // Only a completed instruction loads the output register: any word in
  // EXT (the extension, even a malformed one), or a non-prefix word in IDLE.
  assign w_load = w_in_fire && (w_ext || !w_is_prefix);

  insn_field_decode u_field_decode (
    .i_word     (i_in_instr),
    .i_prefix   (r_prefix),
    .i_ext      (w_ext),
    .o_opcode   (w_dec_opcode),
    .o_rd       (w_dec_rd),
    .o_rs       (w_dec_rs),
    .o_imm_din  (w_dec_imm),
    .o_num_bits (w_dec_num_bits),
    .o_shift    (w_dec_shift),
    .o_illegal  (w_dec_illegal)
  );

  // Decode FSM, prefix holding register and registered output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_prefix       <= 12'h000;
      r_prefix_pc    <= {PC_W{1'b0}};
      r_out_valid    <= 1'b0;
      r_out_opcode   <= 4'h0;
      r_out_rd       <= 4'h0;
      r_out_rs       <= 4'h0;
      r_imm_din      <= 16'h0000;
      r_imm_num_bits <= 2'd0;
      r_imm_shift    <= 2'd0;
      r_out_pc       <= {PC_W{1'b0}};
      r_out_illegal  <= 1'b0;
    end else if (i_flush) begin
      // Flush wins over any handshake in the same cycle
      r_state        <= ST_IDLE;
      r_prefix       <= 12'h000;
      r_prefix_pc    <= {PC_W{1'b0}};
      r_out_valid    <= 1'b0;
      r_out_opcode   <= 4'h0;
      r_out_rd       <= 4'h0;
      r_out_rs       <= 4'h0;
      r_imm_din      <= 16'h0000;
      r_imm_num_bits <= 2'd0;
      r_imm_shift    <= 2'd0;
      r_out_pc       <= {PC_W{1'b0}};
      r_out_illegal  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_in_fire && w_is_prefix) begin
            r_prefix    <= i_in_instr[11:0];
            r_prefix_pc <= i_in_pc;
            r_state     <= ST_EXT;
          end else begin
            r_state     <= ST_IDLE;
          end
        end
        ST_EXT: begin
          // Any accepted word completes the pair, malformed or not
          if (w_in_fire) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_EXT;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      if (w_load) begin
        r_out_valid    <= 1'b1;
        r_out_opcode   <= w_dec_opcode;
        r_out_rd       <= w_dec_rd;
        r_out_rs       <= w_dec_rs;
        r_imm_din      <= w_dec_imm;
        r_imm_num_bits <= w_dec_num_bits;
        r_imm_shift    <= w_dec_shift;
        r_out_illegal  <= w_dec_illegal;
        // A two-word instruction reports the address of its prefix
        if (w_ext) begin
          r_out_pc <= r_prefix_pc;
        end else begin
          r_out_pc <= i_in_pc;
        end
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
    end
  end

  assign o_in_ready     = w_in_ready;
  assign o_out_valid    = r_out_valid;
  assign o_out_opcode   = r_out_opcode;
  assign o_out_rd       = r_out_rd;
  assign o_out_rs       = r_out_rs;
  assign o_imm_din      = r_imm_din;
  assign o_imm_num_bits = r_imm_num_bits;
  assign o_imm_shift    = r_imm_shift;
  assign o_out_pc       = r_out_pc;
  assign o_out_illegal  = r_out_illegal;

endmodule

// File: tb/tb_insn_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_insn_decode_stage
// Directed, table-driven bench for insn_decode_stage plus hand-written
// sequences for back-to-back, prefix, stall, flush, reset and illegal cases.
// Optional feature macro: INSN_DECODE_ILLEGAL_EN (selects expectations).
// -----------------------------------------------------------------------------
module tb_insn_decode_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [15:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_opcode;
  logic [3:0]  out_rd;
  logic [3:0]  out_rs;
  logic [15:0] imm_din;
  logic [1:0]  imm_num_bits;
  logic [1:0]  imm_shift;
  logic [15:0] out_pc;
  logic        out_illegal;

  int n_vec;
  int n_err;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [1:0]  nb;
    logic [1:0]  sh;
  } vec_t;

  vec_t vecs [8];

  insn_decode_stage #(.PC_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_flush        (flush),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .i_in_instr     (in_instr),
    .i_in_pc        (in_pc),
    .o_out_valid    (out_valid),
    .i_out_ready    (out_ready),
    .o_out_opcode   (out_opcode),
    .o_out_rd       (out_rd),
    .o_out_rs       (out_rs),
    .o_imm_din      (imm_din),
    .o_imm_num_bits (imm_num_bits),
    .o_imm_shift    (imm_shift),
    .o_out_pc       (out_pc),
    .o_out_illegal  (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out(input string name, input logic v, input logic [3:0] op,
                           input logic [3:0] rd, input logic [3:0] rs,
                           input logic [15:0] imm, input logic [1:0] nb,
                           input logic [1:0] sh, input logic [15:0] pc,
                           input logic ill);
    logic [49:0] got;
    logic [49:0] exp;
    got = {out_valid, out_opcode, out_rd, out_rs, imm_din, imm_num_bits, imm_shift, out_pc, out_illegal};
    exp = {v, op, rd, rs, imm, nb, sh, pc, ill};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got v=%0b op=%h rd=%h rs=%h imm=%h nb=%0d sh=%0d pc=%h ill=%0b, want v=%0b op=%h rd=%h rs=%h imm=%h nb=%0d sh=%0d pc=%h ill=%0b",
               name, out_valid, out_opcode, out_rd, out_rs, imm_din, imm_num_bits, imm_shift, out_pc, out_illegal,
               v, op, rd, rs, imm, nb, sh, pc, ill);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b want %0b", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 16'h0000;
    in_pc     = 16'h0000;
    out_ready = 1'b1;

    vecs[0] = '{16'hC3A5, 16'h0010, 4'hC, 4'h3, 4'hA, 2'd2, 2'd0};
    vecs[1] = '{16'h1234, 16'h0012, 4'h1, 4'h2, 4'h3, 2'd0, 2'd0};
    vecs[2] = '{16'h7FFF, 16'h0014, 4'h7, 4'hF, 4'hF, 2'd0, 2'd0};
    vecs[3] = '{16'h8123, 16'h0016, 4'h8, 4'h1, 4'h2, 2'd1, 2'd0};
    vecs[4] = '{16'hBEEF, 16'h0018, 4'hB, 4'hE, 4'hE, 2'd1, 2'd0};
    vecs[5] = '{16'hD1F0, 16'h001A, 4'hD, 4'h1, 4'hF, 2'd2, 2'd1};
    vecs[6] = '{16'hE200, 16'h001C, 4'hE, 4'h2, 4'h0, 2'd2, 2'd2};
    vecs[7] = '{16'h0000, 16'h001E, 4'h0, 4'h0, 4'h0, 2'd0, 2'd0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, 4'h0, 4'h0, 4'h0, 16'h0000, 2'd0, 2'd0, 16'h0000, 1'b0);
    check_bit("reset_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    tick();

    // Single-word decode table, streamed back to back
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc    = vecs[i].pc;
      tick();
      in_valid = 1'b0;
      check_out($sformatf("table_%0d", i), 1'b1, vecs[i].op, vecs[i].rd, vecs[i].rs,
                vecs[i].instr, vecs[i].nb, vecs[i].sh, vecs[i].pc, 1'b0);
    end
    tick();
    check_bit("drain_valid", out_valid, 1'b0);

    // Back-to-back branch then load-upper
    in_valid = 1'b1; in_instr = 16'hD1F0; in_pc = 16'h0030;
    tick();
    check_out("b2b_first", 1'b1, 4'hD, 4'h1, 4'hF, 16'hD1F0, 2'd2, 2'd1, 16'h0030, 1'b0);
    check_bit("b2b_in_ready", in_ready, 1'b1);
    in_instr = 16'hE200; in_pc = 16'h0032;
    tick();
    in_valid = 1'b0;
    check_out("b2b_second", 1'b1, 4'hE, 4'h2, 4'h0, 16'hE200, 2'd2, 2'd2, 16'h0032, 1'b0);
    tick();

    // Prefix, idle cycle, extension
    in_valid = 1'b1; in_instr = 16'hF457; in_pc = 16'h0020;
    tick();
    in_valid = 1'b0;
    check_bit("prefix_no_out", out_valid, 1'b0);
    tick();
    check_bit("prefix_idle_no_out", out_valid, 1'b0);
    in_valid = 1'b1; in_instr = 16'h0ABC; in_pc = 16'h0022;
    tick();
    in_valid = 1'b0;
    check_out("prefix_ext", 1'b1, 4'h7, 4'h5, 4'h4, 16'h0ABC, 2'd3, 2'd0, 16'h0020, 1'b0);
    tick();
    check_bit("prefix_single_out", out_valid, 1'b0);

    // Stall with a waiting word behind it
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 16'h8123; in_pc = 16'h0040;
    tick();
    in_instr = 16'h1111; in_pc = 16'h0042;
    for (int c = 0; c < 3; c++) begin
      check_out($sformatf("stall_hold_%0d", c), 1'b1, 4'h8, 4'h1, 4'h2, 16'h8123, 2'd1, 2'd0, 16'h0040, 1'b0);
      check_bit($sformatf("stall_in_ready_%0d", c), in_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check_bit("release_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check_out("release_next", 1'b1, 4'h1, 4'h1, 4'h1, 16'h1111, 2'd0, 2'd0, 16'h0042, 1'b0);
    tick();

    // Flush with a stalled output pending
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 16'h5678; in_pc = 16'h0048;
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_out("flush_output", 1'b0, 4'h0, 4'h0, 4'h0, 16'h0000, 2'd0, 2'd0, 16'h0000, 1'b0);
    out_ready = 1'b1;

    // Flush with a prefix held
    in_valid = 1'b1; in_instr = 16'hF001; in_pc = 16'h0050;
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_bit("flush_prefix_valid", out_valid, 1'b0);
    in_valid = 1'b1; in_instr = 16'h0456; in_pc = 16'h0052;
    tick();
    in_valid = 1'b0;
    check_out("after_flush", 1'b1, 4'h0, 4'h4, 4'h5, 16'h0456, 2'd0, 2'd0, 16'h0052, 1'b0);
    tick();

    // Asynchronous reset in EXT drops the prefix
    in_valid = 1'b1; in_instr = 16'hF123; in_pc = 16'h0058;
    tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_bit("rst_ext_valid", out_valid, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    in_valid = 1'b1; in_instr = 16'h2345; in_pc = 16'h005A;
    tick();
    in_valid = 1'b0;
    check_out("after_rst_ext", 1'b1, 4'h2, 4'h3, 4'h4, 16'h2345, 2'd0, 2'd0, 16'h005A, 1'b0);
    tick();

    // Malformed extension word
    in_valid = 1'b1; in_instr = 16'hF001; in_pc = 16'h0060;
    tick();
    in_instr = 16'h3123; in_pc = 16'h0062;
    tick();
    in_valid = 1'b0;
`ifdef INSN_DECODE_ILLEGAL_EN
    check_out("ext_bad_nibble", 1'b1, 4'h1, 4'h0, 4'h0, 16'h3123, 2'd0, 2'd0, 16'h0060, 1'b1);
`else
    check_out("ext_bad_nibble", 1'b1, 4'h1, 4'h0, 4'h0, 16'h3123, 2'd3, 2'd0, 16'h0060, 1'b0);
`endif
    tick();

    // Extension word that is itself a prefix completes the pair
    in_valid = 1'b1; in_instr = 16'hF021; in_pc = 16'h0070;
    tick();
    in_instr = 16'hF999; in_pc = 16'h0072;
    tick();
    in_valid = 1'b0;
`ifdef INSN_DECODE_ILLEGAL_EN
    check_out("ext_is_prefix", 1'b1, 4'h1, 4'h2, 4'h0, 16'hF999, 2'd0, 2'd0, 16'h0070, 1'b1);
`else
    check_out("ext_is_prefix", 1'b1, 4'h1, 4'h2, 4'h0, 16'hF999, 2'd3, 2'd0, 16'h0070, 1'b0);
`endif
    in_valid = 1'b1; in_instr = 16'h4321; in_pc = 16'h0074;
    tick();
    in_valid = 1'b0;
    check_out("idle_after_ext", 1'b1, 4'h4, 4'h3, 4'h2, 16'h4321, 2'd0, 2'd0, 16'h0074, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/insn_decode_stage.md
Name: insn_decode_stage

Overview:
- Registered decode stage between instruction fetch and the immediate generator / execute stage.
- Accepts 16-bit instruction words over a valid/ready handshake and splits them into opcode and register fields.
- Drives the immediate-generator controls directly: 16-bit raw immediate source, 2-bit width select (0 none, 1 imm4, 2 imm8, 3 imm12) and 2-bit shift select (0 none, 1 <<1, 2 <<8).
- Assembles two-word prefix instructions (opcode 0xF + extension word) with a small FSM.

Parameters:
- PC_W, 16, width of the program counter carried alongside each instruction.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous; discards held prefix and output register
- in_valid  in  1  fetch word valid
- in_ready  out  1  stage can accept a word this cycle
- in_instr  in  16  instruction word
- in_pc  in  PC_W  address of in_instr
- out_valid  out  1  decoded instruction valid
- out_ready  in  1  downstream accepts
- out_opcode  out  4  operation code
- out_rd  out  4  destination register
- out_rs  out  4  source register
- imm_din  out  16  raw immediate source word
- imm_num_bits  out  2  immediate width select
- imm_shift  out  2  immediate shift select
- out_pc  out  PC_W  PC of the first word of the instruction
- out_illegal  out  1  malformed instruction flag

Behaviour:
- Clock/reset: one clock, clk; reset is asynchronous and active-high, named rst.
- Reset values: all outputs 0, FSM in IDLE. in_ready is combinational and therefore 1 after reset.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready = !out_valid || out_ready, with no dependence on in_valid.
  - Output fields are stable while out_valid && !out_ready.
- Decode of word w, where op = w[15:12]:
  - op 0x0-0x7: numBits 0, shift 0.
  - op 0x8-0xB: numBits 1, shift 0.
  - op 0xC: numBits 2, shift 0.
  - op 0xD (branch): numBits 2, shift 1.
  - op 0xE (load-upper): numBits 2, shift 2.
  - For all of the above: out_opcode = op, out_rd = w[11:8], out_rs = w[7:4], imm_din = w.
- FSM states: IDLE, EXT.
  - IDLE, non-prefix word accepted: load output register; out_valid = 1 next cycle (latency 1).
  - IDLE, prefix word (op 0xF) accepted: latch prefix and its PC; go to EXT; out_valid unchanged.
  - EXT, word accepted: load output with out_opcode = prefix[3:0], out_rd = prefix[7:4], out_rs = prefix[11:8], imm_din = ext word, numBits 3, shift 0, out_pc = prefix PC; return to IDLE.
- Stalls: out_valid clears on an output transfer with no new load. A simultaneous transfer and load keeps out_valid = 1 with new contents, giving back-to-back throughput of 1 word per cycle.
- Flush has priority over any transfer that cycle: out_valid → 0, FSM → IDLE, held prefix discarded.
- Async reset mid-EXT drops the held prefix with no output.
- A prefix word never produces an output on its own.

Optional Feature:
- Macro: INSN_DECODE_ILLEGAL_EN.
- Defined: out_illegal = 1 with the instruction when either:
  - an extension word has w[15:12] != 0, or
  - an extension word is itself a prefix (op 0xF).
- Illegal words still complete the handshake and return the FSM to IDLE; imm_num_bits = 0 for illegal outputs.
- Undefined: out_illegal is tied 0 and extension words are accepted unchecked.

Decomposition:
- Package insn_decode_pkg holds:
  - opcode constants OP_PREFIX = 4'hF, OP_BRANCH = 4'hD, OP_LUI = 4'hE;
  - immediate-width enum IMM_NONE/IMM4/IMM8/IMM12 (0-3);
  - shift enum SH_NONE/SH_1/SH_8 (0-2);
  - FSM state type.
- One natural sub-module, insn_field_decode: purely combinational single-word mapping from op to numBits/shift and fields. It is reused for both IDLE and EXT paths.

Test Plan:
- Reset then 0xC3A5 at pc 0x0010 → next cycle out_valid = 1, opcode 0xC, rd 3, rs 0xA, imm_din 0xC3A5, numBits 2, shift 0, out_pc 0x0010.
- 0xD1F0 then 0xE200 back-to-back with out_ready held 1 → two consecutive valid cycles: shift 1 and then shift 2, numBits 2 for both; in_ready stays 1.
- Prefix 0xF457 at pc 0x20, one idle cycle, then 0x0ABC → one output only: opcode 7, rd 5, rs 4, imm_din 0x0ABC, numBits 3, out_pc 0x20.
- out_ready = 0 for 3 cycles holding 0x8123 → outputs stable, in_ready = 0; release → transfer, next word accepted the same cycle.
- Prefix 0xF001 accepted, then flush → out_valid 0, FSM IDLE; next 0x0456 decodes as non-prefix, numBits 0.
- With INSN_DECODE_ILLEGAL_EN: prefix 0xF001 then 0x3123 → out_illegal = 1, numBits 0. Without the macro, the same sequence gives out_illegal = 0, numBits 3.
